// File: rtl/addr_to_cart_pkg.sv
// Shared VGA geometry constants and the fixed-point reciprocal used to divide
// the upper address bits by five.
package vga_pkg;

    localparam int ADDR_W       = 19;
    localparam int COORD_W      = 10;
    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int FRAME_PIXELS = 307200;

    // A 640-pixel line is five 128-pixel blocks: low bits index within a block.
    localparam int BLK_W = 7;
    localparam int DIV_IN_W = ADDR_W - BLK_W;
    localparam int DIV_Q_W  = COORD_W;
    localparam int DIV_R_W  = 3;
    localparam int DIVISOR  = 5;

    // floor(x/5) == (x*3277) >> 14 for every 12-bit x.
    localparam int DIV5_RECIP = 3277;
    localparam int DIV5_SHIFT = 14;
    localparam int DIV5_PROD_W = DIV_IN_W + DIV5_SHIFT - 2;

endpackage

// File: rtl/addr_to_cart_if.sv
// Address-in / coordinate-out bus between the pixel address source and addr_to_cart.
interface addr_to_cart_if;
    import vga_pkg::*;

    logic               in_valid;
    logic [ADDR_W-1:0]  cur_address;
    logic               out_valid;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic               out_of_range;

    modport master (
        output in_valid, cur_address,
        input  out_valid, cur_x, cur_y, out_of_range
    );

    modport slave (
        input  in_valid, cur_address,
        output out_valid, cur_x, cur_y, out_of_range
    );

endinterface

// File: rtl/addr_to_cart_div_by_5.sv
// Combinational 12-bit divide by five via reciprocal multiply, with the
// remainder recovered by back-multiplication.
module div_by_5
    import vga_pkg::*;
(
    input  logic [DIV_IN_W-1:0] dividend,
    output logic [DIV_Q_W-1:0]  quotient,
    output logic [DIV_R_W-1:0]  remainder
);

    localparam logic [DIV5_PROD_W-1:0] RECIP = DIV5_PROD_W'(DIV5_RECIP);
    localparam logic [DIV_IN_W-1:0]    DIV   = DIV_IN_W'(DIVISOR);

    logic [DIV5_PROD_W-1:0] scaled;
    logic [DIV_IN_W-1:0]    back;
    logic [DIV_IN_W-1:0]    diff;

    assign scaled    = DIV5_PROD_W'(dividend) * RECIP;
    assign quotient  = DIV_Q_W'(scaled >> DIV5_SHIFT);
    assign back      = DIV_IN_W'(quotient) * DIV;
    assign diff      = dividend - back;
    assign remainder = DIV_R_W'(diff);

endmodule

// File: rtl/addr_to_cart.sv
// Converts a row-major 640-wide linear pixel address into registered (x, y)
// coordinates with a single-cycle latency and an out-of-frame flag.
module addr_to_cart
    import vga_pkg::*;
#(
    parameter int H_RES = vga_pkg::H_RES,
    parameter int V_RES = vga_pkg::V_RES
) (
    input  logic           clock,
    input  logic           resetn,
    addr_to_cart_if.slave  bus
);

    localparam logic [ADDR_W-1:0] FRAME_LIMIT = ADDR_W'(H_RES * V_RES);

    logic [DIV_IN_W-1:0] blk_idx_p0;
    logic [DIV_Q_W-1:0]  y_p0;
    logic [DIV_R_W-1:0]  blk_col_p0;
    logic [COORD_W-1:0]  x_p0;
    logic                oor_p0;

    logic                vld_p1;
    logic [COORD_W-1:0]  x_p1;
    logic [COORD_W-1:0]  y_p1;
    logic                oor_p1;

    // Stage p0: split address into 128-pixel block index and in-block offset.
    assign blk_idx_p0 = bus.cur_address[ADDR_W-1:BLK_W];

    div_by_5 u_div_by_5 (
        .dividend  (blk_idx_p0),
        .quotient  (y_p0),
        .remainder (blk_col_p0)
    );

    assign x_p0   = {blk_col_p0, bus.cur_address[BLK_W-1:0]};
    assign oor_p0 = (bus.cur_address >= FRAME_LIMIT);

    // Stage p1: output registers; data holds when no valid address arrives.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_p1 <= 1'b0;
            x_p1   <= '0;
            y_p1   <= '0;
            oor_p1 <= 1'b0;
        end else if (bus.in_valid) begin
            vld_p1 <= 1'b1;
            x_p1   <= x_p0;
            y_p1   <= y_p0;
            oor_p1 <= oor_p0;
        end else begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.out_valid    = vld_p1;
    assign bus.cur_x        = x_p1;
    assign bus.cur_y        = y_p1;
    assign bus.out_of_range = oor_p1;

endmodule

// File: tb/tb_addr_to_cart.sv
// Directed self-checking bench for addr_to_cart and its div_by_5 sub-block.
module tb_addr_to_cart;
    import vga_pkg::*;

    logic clock;
    logic resetn;
    int   n_checks;
    int   n_fail;

    addr_to_cart_if bus ();

    addr_to_cart #(.H_RES(640), .V_RES(480)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    logic [11:0] div_in;
    logic [9:0]  div_q;
    logic [2:0]  div_r;

    div_by_5 u_div (
        .dividend  (div_in),
        .quotient  (div_q),
        .remainder (div_r)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive(input logic v, input logic [18:0] a);
        @(negedge clock);
        bus.in_valid    = v;
        bus.cur_address = a;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn          = 1'b0;
        bus.in_valid    = 1'b1;
        bus.cur_address = 19'd1000;
        step();
        step();
        n_checks++;
        if ({bus.out_valid, bus.cur_x, bus.cur_y, bus.out_of_range} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_state got v=%0b x=%0d y=%0d oor=%0b want all 0",
                     bus.out_valid, bus.cur_x, bus.cur_y, bus.out_of_range);
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        resetn       = 1'b1;
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_valid got %0b want 0", bus.out_valid);
        end
    endtask

    task automatic test_basic();
        logic [18:0] addrs [3] = '{19'd0, 19'd639, 19'd640};
        int          ex [3]    = '{0, 639, 0};
        int          ey [3]    = '{0, 0, 1};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, addrs[i]);
            step();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.cur_x !== 10'(ex[i]) ||
                bus.cur_y !== 10'(ey[i]) || bus.out_of_range !== 1'b0) begin
                n_fail++;
                $display("FAIL basic addr=%0d got v=%0b (%0d,%0d) oor=%0b want v=1 (%0d,%0d) oor=0",
                         addrs[i], bus.out_valid, bus.cur_x, bus.cur_y, bus.out_of_range, ex[i], ey[i]);
            end
        end
    endtask

    task automatic test_boundary();
        logic [18:0] addrs [4] = '{19'd307199, 19'd307200, 19'd524287, 19'd307839};
        int          ex [4]    = '{639, 0, 127, 639};
        int          ey [4]    = '{479, 480, 819, 480};
        logic        eo [4]    = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, addrs[i]);
            step();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.cur_x !== 10'(ex[i]) ||
                bus.cur_y !== 10'(ey[i]) || bus.out_of_range !== eo[i]) begin
                n_fail++;
                $display("FAIL boundary addr=%0d got v=%0b (%0d,%0d) oor=%0b want v=1 (%0d,%0d) oor=%0b",
                         addrs[i], bus.out_valid, bus.cur_x, bus.cur_y, bus.out_of_range,
                         ex[i], ey[i], eo[i]);
            end
        end
    endtask

    // Contiguous runs at the frame start and end, then a coarse stride over
    // the whole 19-bit space; in_valid never drops so each cycle is a result.
    task automatic test_sweep();
        int a;
        int starts [3] = '{0, 303999, 0};
        int stops  [3] = '{3199, 307199, 524287};
        int incs   [3] = '{1, 1, 997};
        for (int r = 0; r < 3; r++) begin
            a = starts[r];
            while (a <= stops[r]) begin
                drive(1'b1, 19'(a));
                step();
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.cur_x !== 10'(a % 640) ||
                    bus.cur_y !== 10'(a / 640) || bus.out_of_range !== (a >= 307200)) begin
                    n_fail++;
                    $display("FAIL sweep addr=%0d got v=%0b (%0d,%0d) oor=%0b want v=1 (%0d,%0d) oor=%0b",
                             a, bus.out_valid, bus.cur_x, bus.cur_y, bus.out_of_range,
                             a % 640, a / 640, a >= 307200);
                end
                a += incs[r];
            end
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 19'd1000);
        step();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.cur_x !== 10'd360 || bus.cur_y !== 10'd1) begin
            n_fail++;
            $display("FAIL hold_load got v=%0b (%0d,%0d) want v=1 (360,1)",
                     bus.out_valid, bus.cur_x, bus.cur_y);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 19'd524287);
            step();
            n_checks++;
            if (bus.out_valid !== 1'b0 || bus.cur_x !== 10'd360 ||
                bus.cur_y !== 10'd1 || bus.out_of_range !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_idle cycle=%0d got v=%0b (%0d,%0d) oor=%0b want v=0 (360,1) oor=0",
                         i, bus.out_valid, bus.cur_x, bus.cur_y, bus.out_of_range);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 19'd5000);
        step();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.cur_x !== 10'd520 || bus.cur_y !== 10'd7) begin
            n_fail++;
            $display("FAIL areset_pre got v=%0b (%0d,%0d) want v=1 (520,7)",
                     bus.out_valid, bus.cur_x, bus.cur_y);
        end
        bus.cur_address = 19'd6000;
        #1;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.cur_x, bus.cur_y, bus.out_of_range} !== 22'd0) begin
            n_fail++;
            $display("FAIL areset_immediate got v=%0b x=%0d y=%0d oor=%0b want all 0",
                     bus.out_valid, bus.cur_x, bus.cur_y, bus.out_of_range);
        end
        step();
        n_checks++;
        if ({bus.out_valid, bus.cur_x, bus.cur_y} !== 21'd0) begin
            n_fail++;
            $display("FAIL areset_held got v=%0b x=%0d y=%0d want all 0",
                     bus.out_valid, bus.cur_x, bus.cur_y);
        end
        @(negedge clock);
        resetn = 1'b1;
        step();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.cur_x !== 10'd240 ||
            bus.cur_y !== 10'd9 || bus.out_of_range !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_recover got v=%0b (%0d,%0d) oor=%0b want v=1 (240,9) oor=0",
                     bus.out_valid, bus.cur_x, bus.cur_y, bus.out_of_range);
        end
    endtask

    task automatic test_div_by_5();
        for (int i = 0; i < 4096; i++) begin
            div_in = 12'(i);
            #1;
            n_checks++;
            if (div_q !== 10'(i / 5) || div_r !== 3'(i % 5)) begin
                n_fail++;
                $display("FAIL div_by_5 in=%0d got q=%0d r=%0d want q=%0d r=%0d",
                         i, div_q, div_r, i / 5, i % 5);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        div_in   = '0;
        test_reset();
        test_basic();
        test_boundary();
        test_hold();
        test_async_reset();
        test_sweep();
        test_div_by_5();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
